multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle sequencer for the ARMv4 core: one FSM steps the shared ALU, memory port and register file through fetch, decode, execute and writeback.
//  It owns the NZCV flags register and the condition-code check.
//  Per-state datapath controls use the existing ALUControl encoding.
//  Sits between the instruction register and the datapath muxes/enables; the memory port may stall it.
// PARAMETERS
//  FETCH_TIMEOUT  16  max FETCH wait cycles for MemReady before Fault pulses (0 = disabled)
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high
//  Instr       in   32  IR contents: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12] sh[6:5]
//  ALUFlags    in   4   {N,Z,C,V} from ALU, current cycle
//  MemReady    in   1   memory completes current access this cycle
//  PCWrite     out  1   load PC
//  IRWrite     out  1   load IR
//  AdrSrc      out  1   0 = PC, 1 = ALUOut as memory address
//  MemRead     out  1   read request, held until MemReady
//  MemWrite    out  1   write request, held until MemReady
//  RegWrite    out  1   register file write
//  ALUSrcA     out  1   0 = reg A, 1 = PC
//  ALUSrcB     out  2   00 = reg B, 01 = ExtImm, 10 = const 4
//  ResultSrc   out  2   00 = ALUOut, 01 = MemData, 10 = ALU direct
//  ALUControl  out  4   0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 1001 ROR
//  ImmSrc      out  2   00 DP imm, 01 mem offset, 10 branch
//  RegSrc      out  2   [0] read R15, [1] second read port = Rd
//  FlagsQ      out  4   registered {N,Z,C,V}
//  State       out  4   FSM state encoding (debug)
//  Fault       out  1   one-cycle pulse on fetch timeout
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9; codes 10-15 go to FETCH next cycle.
//  - Reset, async: State=FETCH, FlagsQ=0, timeout count=0. While reset=1, PCWrite, IRWrite, MemRead, MemWrite, RegWrite and Fault are forced to 0.
//  - FETCH: AdrSrc=0, MemRead=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
//    - PCWrite and IRWrite are 1 only when MemReady=1; FSM then goes to DECODE, else it stays in FETCH.
//    - On timeout: Fault pulses, count clears, request continues.
//  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ImmSrc/RegSrc decoded from Op (PC+8 for R15).
//    - CondEx = cond(Cond, FlagsQ), with EQ..LE per ARM and 1110 = always; 1111 is false.
//    - !CondEx -> FETCH. Else by Op:
//      - 00 -> EXECI if Funct[5], else EXECR
//      - 01 -> MEMADR
//      - 10 -> BRANCH
//      - 11 -> FETCH (NOP)
//  - MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD. Next: MEMRD if Funct[0] (LDR), else MEMWR (RegSrc[1]=1).
//  - MEMRD: AdrSrc=1, MemRead=1; stay until MemReady, then MEMWB.
//  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//  - MEMWR: AdrSrc=1, MemWrite=1; stay until MemReady, then FETCH.
//  - EXECR/EXECI: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI), ImmSrc=00. ALUControl from Funct[4:1]:
//    - 0000 AND, 0001 XOR, 0010 SUB, 0100 ADD, 1100 OR, 1111 NOT
//    - 1101 with sh=11 -> ROR
//    - 1010 -> SUB (CMP)
//    - any other -> ADD with writeback suppressed
//  - EXECR/EXECI next state: ALUWB, or FETCH for CMP or suppressed ops.
//  - Flags update at end of the EXEC cycle when Funct[0]=1 or CMP:
//    - ADD/SUB/CMP load all four flags.
//    - Logic ops and ROR load N,Z only; C,V hold.
//  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=0, RegSrc[0]=1, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=1 -> FETCH.
//  - Outputs not named in a state are 0; ALUControl defaults to ADD.
//  - Latency with MemReady=1: DP 4 cycles, LDR 5, STR 4, B 3, CMP 3, failed condition 2.
//  - Reset mid-access drops MemRead/MemWrite in the same cycle; no flag or register write completes.
// TESTING
//  - reset high 3 cycles, release, MemReady=1, Instr=ADD r1,r2,r3 (E0821003) -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUControl=0000 in EXECR.
//  - FlagsQ=0100, Instr=SUBS EQ (0x0...S=1), ALUFlags=1000 -> executes; FlagsQ=1000 after EXEC. Same with NE cond -> DECODE to FETCH, 2 cycles, no writes.
//  - LDR with MemReady low 3 cycles in MEMRD -> MemRead held 4 cycles, AdrSrc=1 throughout, then MEMWB RegWrite=1, ResultSrc=01.
//  - CMP (Funct=010101), ALUFlags=0110 -> ALUControl=0001, FlagsQ=0110, no ALUWB, back to FETCH after 3 cycles.
//  - MemReady held 0 in FETCH for 20 cycles -> Fault pulses once at cycle 16; PCWrite/IRWrite stay 0.
//  - reset asserted during MEMWR -> MemWrite=0 immediately, State=0, FlagsQ=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Groups every signal that passes between the multicycle controller and the
// ARMv4 datapath, so both sides connect with one port.
//
//   master modport : the controller side (reads IR/flags/ready, drives controls)
//   slave modport  : the datapath side (drives IR/flags/ready, reads controls)
//
//   Instr       32  IR contents: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12] sh[6:5]
//   ALUFlags     4  {N,Z,C,V} from the ALU, current cycle
//   MemReady     1  memory completes the current access this cycle
//   PCWrite/IRWrite/RegWrite/MemRead/MemWrite   1-bit enables and requests
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc   datapath mux selects
//   ALUControl   4  ALU operation code
//   FlagsQ       4  registered {N,Z,C,V}
//   State        4  FSM state code (debug)
//   Fault        1  one-cycle pulse on fetch timeout
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;

    logic        PCWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [3:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [3:0]  FlagsQ;
    logic [3:0]  State;
    logic        Fault;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc,
               FlagsQ, State, Fault
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc,
               FlagsQ, State, Fault
    );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Multicycle sequencer for the ARMv4 core. One FSM steps the shared ALU,
// memory port and register file through fetch, decode, execute and
// writeback. It also owns the NZCV flags register and the condition check.
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-high; forces all enables/requests low
//   bus    multicycle_controller_if.master (IR, ALU flags, memory ready in;
//          datapath enables, mux selects, ALUControl, FlagsQ, State, Fault out)
//
// Parameter:
//   FETCH_TIMEOUT  cycles FETCH may wait for MemReady before Fault pulses
//                  (0 disables the check)
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // Data-processing classes: they decide writeback and which flags load.
    typedef enum logic [1:0] {
        DP_NONE,
        DP_ARITH,
        DP_LOGIC,
        DP_CMP
    } dp_kind_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b1001;

    localparam int              CW         = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0]   WAIT_LIMIT = CW'(FETCH_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  flags_q;
    logic [CW-1:0] wait_cnt;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [1:0]  sh;
    logic        cond_ex;
    logic [3:0]  dp_alu;
    dp_kind_t    dp_kind;
    logic        fetch_waiting;
    logic        timeout_hit;

    logic        pc_write;
    logic        ir_write;
    logic        adr_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic [1:0]  imm_src;
    logic [1:0]  reg_src;

    logic        unused_instr_bits;

    assign cond  = bus.Instr[31:28];
    assign op    = bus.Instr[27:26];
    assign funct = bus.Instr[25:20];
    assign sh    = bus.Instr[6:5];

    // Register numbers and the remaining immediate bits belong to the datapath.
    assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:7], bus.Instr[4:0]};

    // Condition check against the registered flags, ARM encoding.
    // 1110 is "always"; 1111 is treated as never.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = !flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = !flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = !flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = !flags_q[0];
            4'b1000: cond_ex = flags_q[1] && !flags_q[2];
            4'b1001: cond_ex = !flags_q[1] || flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing decode from Funct[4:1]. Anything not listed runs as an
    // ADD with no writeback and no flag update, so it behaves like a NOP.
    always_comb begin
        dp_alu  = ALU_ADD;
        dp_kind = DP_NONE;
        case (funct[4:1])
            4'b0000: begin dp_alu = ALU_AND; dp_kind = DP_LOGIC; end
            4'b0001: begin dp_alu = ALU_XOR; dp_kind = DP_LOGIC; end
            4'b0010: begin dp_alu = ALU_SUB; dp_kind = DP_ARITH; end
            4'b0100: begin dp_alu = ALU_ADD; dp_kind = DP_ARITH; end
            4'b1100: begin dp_alu = ALU_OR;  dp_kind = DP_LOGIC; end
            4'b1111: begin dp_alu = ALU_NOT; dp_kind = DP_LOGIC; end
            4'b1101: begin
                if (sh == 2'b11) begin
                    dp_alu  = ALU_ROR;
                    dp_kind = DP_LOGIC;
                end
            end
            4'b1010: begin dp_alu = ALU_SUB; dp_kind = DP_CMP; end
            default: begin dp_alu = ALU_ADD; dp_kind = DP_NONE; end
        endcase
    end

    // A fetch that waits FETCH_TIMEOUT cycles raises Fault for one cycle and
    // restarts the count; the read request itself is never abandoned.
    assign fetch_waiting = (state == FETCH) && !bus.MemReady;
    assign timeout_hit   = (FETCH_TIMEOUT != 0) && fetch_waiting && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (timeout_hit || !fetch_waiting) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Flags load at the end of an EXEC cycle. Arithmetic and CMP take all of
    // NZCV; logic ops and ROR take only N and Z so C and V survive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (state == EXECR || state == EXECI) begin
            if (dp_kind == DP_CMP || (dp_kind == DP_ARITH && funct[0])) begin
                flags_q <= bus.ALUFlags;
            end else if (dp_kind == DP_LOGIC && funct[0]) begin
                flags_q[3:2] <= bus.ALUFlags[3:2];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next state and per-state datapath controls. Everything defaults to 0
    // with the ALU on ADD; unused state codes fall back to FETCH.
    always_comb begin
        next_state  = FETCH;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 2'b00;
        reg_src     = 2'b00;

        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (bus.MemReady) begin
                    pc_write   = 1'b1;
                    ir_write   = 1'b1;
                    next_state = DECODE;
                end else begin
                    next_state = FETCH;
                end
            end

            DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op)
                    2'b01:   imm_src = 2'b01;
                    2'b10:   imm_src = 2'b10;
                    default: imm_src = 2'b00;
                endcase
                reg_src = {op == 2'b01, op == 2'b10};
                if (!cond_ex) begin
                    next_state = FETCH;
                end else begin
                    case (op)
                        2'b00:   next_state = funct[5] ? EXECI : EXECR;
                        2'b01:   next_state = MEMADR;
                        2'b10:   next_state = BRANCH;
                        default: next_state = FETCH;
                    endcase
                end
            end

            MEMADR: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b01;
                reg_src[1] = !funct[0];
                next_state = funct[0] ? MEMRD : MEMWR;
            end

            MEMRD: begin
                adr_src    = 1'b1;
                mem_read   = 1'b1;
                next_state = bus.MemReady ? MEMWB : MEMRD;
            end

            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                next_state = FETCH;
            end

            MEMWR: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                next_state = bus.MemReady ? FETCH : MEMWR;
            end

            EXECR, EXECI: begin
                alu_src_b   = (state == EXECI) ? 2'b01 : 2'b00;
                alu_control = dp_alu;
                next_state  = (dp_kind == DP_CMP || dp_kind == DP_NONE) ? FETCH : ALUWB;
            end

            ALUWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end

            BRANCH: begin
                reg_src    = 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                next_state = FETCH;
            end

            default: next_state = FETCH;
        endcase
    end

    // Reset kills every enable and request immediately, even mid-access.
    assign bus.PCWrite    = pc_write  && !reset;
    assign bus.IRWrite    = ir_write  && !reset;
    assign bus.MemRead    = mem_read  && !reset;
    assign bus.MemWrite   = mem_write && !reset;
    assign bus.RegWrite   = reg_write && !reset;
    assign bus.Fault      = timeout_hit && !reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src;
    assign bus.RegSrc     = reg_src;
    assign bus.FlagsQ     = flags_q;
    assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Drives the controller with directed and random ARMv4 instructions and
// compares every output, every cycle, against an instruction-level model
// that knows the state path, stall behaviour and NZCV rules.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multicycle_controller_if bus();

    multicycle_controller #(
        .FETCH_TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [3:0] modelFlags = 4'b0000;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // ARM condition codes grouped by pairs: odd codes invert the even one.
    function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0]) r = (cond == 4'hF) ? 1'b0 : !r;
        return r;
    endfunction

    // Opcode table: kind 0 = no writeback, 1 = arithmetic, 2 = logic, 3 = compare.
    function automatic void dpDecode(input logic [3:0] f4, input logic [1:0] sh,
                                     output logic [3:0] alu, output int kind);
        alu = 4'b0000;
        kind = 0;
        case (f4)
            4'b0000: begin alu = 4'b0010; kind = 2; end
            4'b0001: begin alu = 4'b0100; kind = 2; end
            4'b0010: begin alu = 4'b0001; kind = 1; end
            4'b0100: begin alu = 4'b0000; kind = 1; end
            4'b1100: begin alu = 4'b0011; kind = 2; end
            4'b1111: begin alu = 4'b0101; kind = 2; end
            4'b1101: if (sh == 2'b11) begin alu = 4'b1001; kind = 2; end
            4'b1010: begin alu = 4'b0001; kind = 3; end
            default: begin alu = 4'b0000; kind = 0; end
        endcase
    endfunction

    function automatic logic [31:0] randomInstr();
        logic [3:0] dpCodes [0:8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1100,
                                      4'b1111, 4'b1101, 4'b1010, 4'b0011};
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [1:0] sh;
        logic [3:0] f4;
        logic [3:0] alu;
        int kind;
        logic s;
        cond  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
        op    = 2'($urandom);
        sh    = 2'($urandom);
        funct = 6'($urandom);
        if (op == 2'b00) begin
            f4 = dpCodes[$urandom_range(0, 8)];
            dpDecode(f4, sh, alu, kind);
            s = 1'($urandom);
            if (kind == 3) s = 1'b1;
            if (kind == 0) s = 1'b0;
            funct = {1'($urandom), f4, s};
        end
        return {cond, op, funct, 4'($urandom), 4'($urandom), 5'($urandom), sh, 5'($urandom)};
    endfunction

    // Runs one instruction from FETCH back to FETCH, checking every cycle.
    // fetchStall/memStall are the cycles MemReady stays low in FETCH and in
    // MEMRD/MEMWR; execFlags is what the ALU reports in the EXEC cycle.
    task automatic applyStimulus(input logic [31:0] instr, input int fetchStall,
                                 input int memStall, input logic [3:0] execFlags);
        int path[$];
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] alu;
        int kind;
        op    = instr[27:26];
        funct = instr[25:20];
        dpDecode(funct[4:1], instr[6:5], alu, kind);

        path.push_back(0);
        path.push_back(1);
        if (condHolds(instr[31:28], modelFlags)) begin
            case (op)
                2'b00: begin
                    path.push_back(funct[5] ? 7 : 6);
                    if (kind == 1 || kind == 2) path.push_back(8);
                end
                2'b01: begin
                    path.push_back(2);
                    if (funct[0]) begin
                        path.push_back(3);
                        path.push_back(4);
                    end else begin
                        path.push_back(5);
                    end
                end
                2'b10: path.push_back(9);
                default: ;
            endcase
        end

        bus.Instr = instr;
        foreach (path[i]) begin
            int s;
            int stalls;
            s = path[i];
            stalls = (s == 0) ? fetchStall : ((s == 3 || s == 5) ? memStall : 0);
            for (int k = 0; k <= stalls; k++) begin
                bit ready;
                int expSrcB;
                int expRes;
                int expRegSrc;
                ready = (k == stalls);
                bus.MemReady = ready;
                bus.ALUFlags = (s == 6 || s == 7) ? execFlags : 4'($urandom);
                expSrcB   = (s == 0 || s == 1) ? 2 : ((s == 7 || s == 2 || s == 9) ? 1 : 0);
                expRes    = (s == 0 || s == 9) ? 2 : ((s == 4) ? 1 : 0);
                expRegSrc = (s == 9) ? 1 :
                            (s == 1) ? (((op == 2'b01) ? 2 : 0) + ((op == 2'b10) ? 1 : 0)) :
                            (s == 2) ? (funct[0] ? 0 : 2) : 0;
                @(negedge clk);
                checkOutput("State",     32'(bus.State),      32'(s));
                checkOutput("PCWrite",   32'(bus.PCWrite),    32'((s == 0 && ready) || s == 9));
                checkOutput("IRWrite",   32'(bus.IRWrite),    32'(s == 0 && ready));
                checkOutput("MemRead",   32'(bus.MemRead),    32'(s == 0 || s == 3));
                checkOutput("MemWrite",  32'(bus.MemWrite),   32'(s == 5));
                checkOutput("RegWrite",  32'(bus.RegWrite),   32'(s == 4 || s == 8));
                checkOutput("AdrSrc",    32'(bus.AdrSrc),     32'(s == 3 || s == 5));
                checkOutput("ALUSrcA",   32'(bus.ALUSrcA),    32'(s == 0 || s == 1));
                checkOutput("ALUSrcB",   32'(bus.ALUSrcB),    32'(expSrcB));
                checkOutput("ResultSrc", 32'(bus.ResultSrc),  32'(expRes));
                checkOutput("RegSrc",    32'(bus.RegSrc),     32'(expRegSrc));
                checkOutput("ALUControl",32'(bus.ALUControl), (s == 6 || s == 7) ? 32'(alu) : 32'd0);
                checkOutput("Fault",     32'(bus.Fault),      32'(s == 0 && !ready && ((k + 1) % 16 == 0)));
                if (s == 1 && op != 2'b11) checkOutput("ImmSrc", 32'(bus.ImmSrc), 32'(op));
                @(posedge clk);
                #1;
            end
            if (s == 6 || s == 7) begin
                if (kind == 3 || (kind == 1 && funct[0])) modelFlags = execFlags;
                else if (kind == 2 && funct[0]) modelFlags[3:2] = execFlags[3:2];
            end
        end
        checkOutput("FlagsQ", 32'(bus.FlagsQ), 32'(modelFlags));
    endtask

    initial begin
        bus.Instr    = 32'h0;
        bus.ALUFlags = 4'h0;
        bus.MemReady = 1'b1;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst State",   32'(bus.State),   32'd0);
        checkOutput("rst MemRead", 32'(bus.MemRead), 32'd0);
        checkOutput("rst PCWrite", 32'(bus.PCWrite), 32'd0);
        checkOutput("rst IRWrite", 32'(bus.IRWrite), 32'd0);
        checkOutput("rst FlagsQ",  32'(bus.FlagsQ),  32'd0);
        checkOutput("rst Fault",   32'(bus.Fault),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(32'hE0821003, 0, 0, 4'b0000);   // ADD r1,r2,r3
        applyStimulus(32'hE0921003, 0, 0, 4'b0100);   // ADDS: FlagsQ -> 0100
        applyStimulus(32'h00521003, 0, 0, 4'b1000);   // SUBS EQ: taken, FlagsQ -> 1000
        applyStimulus(32'hE0921003, 0, 0, 4'b0100);   // back to 0100
        applyStimulus(32'h10521003, 0, 0, 4'b1000);   // SUBS NE: skipped
        applyStimulus(32'hE5921000, 0, 3, 4'b0000);   // LDR with 3 stall cycles
        applyStimulus(32'hE1520003, 0, 0, 4'b0110);   // CMP: FlagsQ -> 0110
        applyStimulus(32'hEC000000, 20, 0, 4'b0000);  // fetch wait of 20 cycles
        applyStimulus(32'hEA000004, 0, 0, 4'b0000);   // B

        for (int n = 0; n < 120; n++) begin
            applyStimulus(randomInstr(), $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom));
        end

        // Reset in the middle of a stalled store.
        applyStimulus(32'hE0921003, 0, 0, 4'b1111);
        bus.Instr = 32'hE5821000;
        for (int i = 0; i < 3; i++) begin
            bus.MemReady = 1'b1;
            @(negedge clk);
            checkOutput("str State", 32'(bus.State), 32'(i == 2 ? 2 : i));
            @(posedge clk);
            #1;
        end
        bus.MemReady = 1'b0;
        @(negedge clk);
        checkOutput("memwr State",    32'(bus.State),    32'd5);
        checkOutput("memwr MemWrite", 32'(bus.MemWrite), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst MemWrite", 32'(bus.MemWrite), 32'd0);
        checkOutput("midrst State",    32'(bus.State),    32'd0);
        checkOutput("midrst FlagsQ",   32'(bus.FlagsQ),   32'd0);
        checkOutput("midrst RegWrite", 32'(bus.RegWrite), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelFlags = 4'b0000;
        applyStimulus(32'hE0821003, 1, 0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
